// File: rtl/led_scan_ctrl_pkg.sv
// Shared constants for the LED scan controller and its tick generator.
// Also provides a counter-width helper usable by other tick-based blocks.
package led_scan_ctrl_pkg;

   localparam logic [7:0] ASCII_BLANK = 8'h20;
   localparam logic [7:0] DIG_ALL_OFF = 8'hFF;

   localparam int DEF_NUM_DIGITS = 8;
   localparam int DEF_SCAN_DIV   = 100000;
   localparam int DEF_BLANK_CYC  = 2000;

   // A divide-by-1 counter still needs one bit to exist.
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running 0..DIV-1 counter with a one-cycle wrap pulse on the last count.
// Shared by the display scanner and the key-debounce sampler.
module scan_tick_gen
   import led_scan_ctrl_pkg::*;
#(
   parameter int DIV = DEF_SCAN_DIV,
   parameter int CW  = cnt_width(DIV)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_comb begin
      wrap     = (cnt_reg == LAST);
      cnt_next = wrap ? '0 : cnt_reg + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_reg <= '0;
      else     cnt_reg <= cnt_next;
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/led_scan_ctrl.sv
// 8-character ASCII display buffer, time-multiplexed onto a common-segment
// display with a blanking gap at the start of every digit slot.
module led_scan_ctrl
   import led_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int SCAN_DIV   = DEF_SCAN_DIV,
   parameter int BLANK_CYC  = DEF_BLANK_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       push_en,
   input  logic [7:0] push_data,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic [7:0] char_out,
   output logic [7:0] dig_sel
);

   localparam int CW = cnt_width(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          wrap;
   logic [IW-1:0] idx_reg;
   logic [IW-1:0] idx_next;
   logic [7:0]    buf_reg  [NUM_DIGITS];
   logic [7:0]    buf_next [NUM_DIGITS];
   logic [7:0]    char_reg;
   logic [7:0]    char_next;
   logic [7:0]    dig_reg;
   logic [7:0]    dig_next;
   logic          blank;

   scan_tick_gen #(
      .DIV (SCAN_DIV),
      .CW  (CW)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt),
      .wrap (wrap)
   );

   // Buffer update: clear beats push beats direct write; losers are dropped.
   always_comb begin
      buf_next = buf_reg;
      if (clr) begin
         for (int i = 0; i < NUM_DIGITS; i++) buf_next[i] = ASCII_BLANK;
      end else if (push_en) begin
         buf_next[0] = push_data;
         for (int i = 1; i < NUM_DIGITS; i++) buf_next[i] = buf_reg[i-1];
      end else if (wr_en) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_addr == 3'(i)) buf_next[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) buf_reg[i] <= ASCII_BLANK;
      end else begin
         buf_reg <= buf_next;
      end
   end

   // Outputs are derived from next-state scan position so they move with cnt/idx.
   always_comb begin
      cnt_next  = wrap ? '0 : cnt + CW'(1);
      idx_next  = idx_reg;
      if (wrap) idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
      blank     = (cnt_next < BLANK_LIM);
      dig_next  = DIG_ALL_OFF;
      if (!blank) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_next == IW'(i)) dig_next[i] = 1'b0;
         end
      end
      char_next = buf_reg[idx_next];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg  <= '0;
         dig_reg  <= DIG_ALL_OFF;
         char_reg <= ASCII_BLANK;
      end else begin
         idx_reg  <= idx_next;
         dig_reg  <= dig_next;
         char_reg <= char_next;
      end
   end

   assign char_out = char_reg;
   assign dig_sel  = dig_reg;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with a short scan period (4 cycles, 1 blank).
// Each scenario task drives stimulus and checks dig_sel/char_out inline.
module tb_led_scan_ctrl;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int ND = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       push_en = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = 3'd0;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] char_out;
   logic [7:0] dig_sel;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   logic [7:0] exp_buf [ND];
   logic [7:0] snap    [ND];

   led_scan_ctrl #(
      .NUM_DIGITS (ND),
      .SCAN_DIV   (SD),
      .BLANK_CYC  (BC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push_en   (push_en),
      .push_data (push_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .char_out  (char_out),
      .dig_sel   (dig_sel)
   );

   always #5 clk = ~clk;

   // Edges seen since reset release; slot = cyc/SD, position in slot = cyc%SD.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [7:0] exp_dig_f(input int c);
      logic [7:0] one;
      one = 8'h01;
      if ((c % SD) < BC) return 8'hFF;
      return ~(one << ((c / SD) % ND));
   endfunction

   // Continuous structural check on dig_sel: never two digits on, blank gap between digits.
   initial begin : dig_checker
      int   run;
      bit   have_prev;
      logic [7:0] prev;
      int   z;
      run = 0; have_prev = 0; prev = 8'hFF;
      forever begin
         @(negedge clk);
         if (rst) begin
            run = 0; have_prev = 0;
         end else begin
            z = 0;
            for (int b = 0; b < 8; b++) if (!dig_sel[b]) z++;
            n_checks++;
            if (z > 1) begin
               n_fail++;
               $display("FAIL onehot: dig_sel=%h has %0d low bits, at most 1 allowed", dig_sel, z);
            end
            if (dig_sel == 8'hFF) begin
               run++;
            end else begin
               if (have_prev && dig_sel != prev) begin
                  n_checks++;
                  if (run < BC) begin
                     n_fail++;
                     $display("FAIL blank_gap: %0d blank cycles before dig_sel=%h, need >= %0d", run, dig_sel, BC);
                  end
               end
               prev = dig_sel; have_prev = 1; run = 0;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clr = 0; push_en = 0; wr_en = 0;
      for (int i = 0; i < ND; i++) exp_buf[i] = 8'h20;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] tbl [8];
      tbl = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD};
      @(negedge clk);
      n_checks += 2;
      if (dig_sel !== 8'hFF) begin n_fail++; $display("FAIL reset_dig: dig_sel=%h expected ff", dig_sel); end
      if (char_out !== 8'h20) begin n_fail++; $display("FAIL reset_char: char_out=%h expected 20", char_out); end
      rst = 1'b0;
      for (int i = 0; i < ND; i++) exp_buf[i] = 8'h20;
      for (int k = 0; k < 2 * SD * ND; k++) begin
         @(negedge clk);
         n_checks += 2;
         if (cyc < 8) begin
            n_checks++;
            if (dig_sel !== tbl[cyc]) begin n_fail++; $display("FAIL reset_seq: cyc=%0d dig_sel=%h expected %h", cyc, dig_sel, tbl[cyc]); end
         end
         if (dig_sel !== exp_dig_f(cyc)) begin n_fail++; $display("FAIL idle_dig: cyc=%0d dig_sel=%h expected %h", cyc, dig_sel, exp_dig_f(cyc)); end
         if (char_out !== 8'h20) begin n_fail++; $display("FAIL idle_char: cyc=%0d char_out=%h expected 20", cyc, char_out); end
      end
      $display("test_reset done: two idle frames scanned");
   endtask

   task automatic test_write();
      do_reset();
      wr_en = 1; wr_addr = 3'd3; wr_data = 8'h41;
      exp_buf[3] = 8'h41;
      @(negedge clk);
      wr_en = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         n_checks += 2;
         if (dig_sel !== exp_dig_f(cyc)) begin n_fail++; $display("FAIL write_dig: cyc=%0d dig_sel=%h expected %h", cyc, dig_sel, exp_dig_f(cyc)); end
         if (char_out !== exp_buf[(cyc / SD) % ND]) begin n_fail++; $display("FAIL write_char: cyc=%0d char_out=%h expected %h", cyc, char_out, exp_buf[(cyc / SD) % ND]); end
      end
      $display("test_write done: wrote 41 to entry 3");
   endtask

   task automatic test_push();
      do_reset();
      for (int p = 0; p < 3; p++) begin
         push_en = 1; push_data = 8'h31 + 8'(p);
         @(negedge clk);
      end
      push_en = 0;
      exp_buf[0] = 8'h33; exp_buf[1] = 8'h32; exp_buf[2] = 8'h31;
      @(negedge clk);
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         n_checks++;
         if (char_out !== exp_buf[(cyc / SD) % ND]) begin n_fail++; $display("FAIL push3_char: cyc=%0d char_out=%h expected %h", cyc, char_out, exp_buf[(cyc / SD) % ND]); end
      end
      for (int p = 3; p < 9; p++) begin
         push_en = 1; push_data = 8'h31 + 8'(p);
         @(negedge clk);
      end
      push_en = 0;
      for (int i = 0; i < ND; i++) exp_buf[i] = 8'h39 - 8'(i);
      @(negedge clk);
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         n_checks++;
         if (char_out !== exp_buf[(cyc / SD) % ND]) begin n_fail++; $display("FAIL push9_char: cyc=%0d char_out=%h expected %h", cyc, char_out, exp_buf[(cyc / SD) % ND]); end
      end
      $display("test_push done: 9 pushes, oldest discarded");
   endtask

   task automatic test_priority();
      do_reset();
      push_en = 1; push_data = 8'h31;
      @(negedge clk);
      clr = 1; push_en = 1; push_data = 8'h37; wr_en = 1; wr_addr = 3'd5; wr_data = 8'h42;
      @(negedge clk);
      clr = 0; push_en = 0; wr_en = 0;
      @(negedge clk);
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         n_checks++;
         if (char_out !== 8'h20) begin n_fail++; $display("FAIL clr_prio: cyc=%0d char_out=%h expected 20", cyc, char_out); end
      end
      push_en = 1; push_data = 8'h35; wr_en = 1; wr_addr = 3'd0; wr_data = 8'h46;
      exp_buf[0] = 8'h35;
      @(negedge clk);
      push_en = 0; wr_en = 0;
      @(negedge clk);
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         n_checks++;
         if (char_out !== exp_buf[(cyc / SD) % ND]) begin n_fail++; $display("FAIL push_prio: cyc=%0d char_out=%h expected %h", cyc, char_out, exp_buf[(cyc / SD) % ND]); end
      end
      $display("test_priority done: clr>push>wr");
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int p = 0; p < 6; p++) begin
         push_en = 1; push_data = 8'h41 + 8'(p);
         @(negedge clk);
      end
      push_en = 0;
      for (int k = 0; k < 100 && cyc != 22; k++) @(negedge clk);
      n_checks += 3;
      if (cyc != 22) begin n_fail++; $display("FAIL async_wait: cyc=%0d never reached 22", cyc); end
      if (dig_sel !== 8'hDF) begin n_fail++; $display("FAIL pre_rst_dig: dig_sel=%h expected df", dig_sel); end
      if (char_out !== 8'h41) begin n_fail++; $display("FAIL pre_rst_char: char_out=%h expected 41", char_out); end
      #2 rst = 1'b1;
      #1;
      n_checks += 2;
      if (dig_sel !== 8'hFF) begin n_fail++; $display("FAIL async_dig: dig_sel=%h expected ff", dig_sel); end
      if (char_out !== 8'h20) begin n_fail++; $display("FAIL async_char: char_out=%h expected 20", char_out); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < ND; i++) exp_buf[i] = 8'h20;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         n_checks += 2;
         if (dig_sel !== exp_dig_f(cyc)) begin n_fail++; $display("FAIL restart_dig: cyc=%0d dig_sel=%h expected %h", cyc, dig_sel, exp_dig_f(cyc)); end
         if (char_out !== 8'h20) begin n_fail++; $display("FAIL restart_char: cyc=%0d char_out=%h expected 20", cyc, char_out); end
      end
      $display("test_async_reset done: reset at idx 5, restart at slot 0");
   endtask

   task automatic test_random();
      int r;
      logic [7:0] pd, wd;
      logic [2:0] wa;
      do_reset();
      snap = exp_buf;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         n_checks += 2;
         if (dig_sel !== exp_dig_f(cyc)) begin n_fail++; $display("FAIL rand_dig: cyc=%0d dig_sel=%h expected %h", cyc, dig_sel, exp_dig_f(cyc)); end
         if (char_out !== snap[(cyc / SD) % ND]) begin n_fail++; $display("FAIL rand_char: cyc=%0d char_out=%h expected %h", cyc, char_out, snap[(cyc / SD) % ND]); end
         snap = exp_buf;
         r  = $urandom_range(0, 19);
         pd = 8'($urandom_range(0, 255));
         wd = 8'($urandom_range(0, 255));
         wa = 3'($urandom_range(0, 7));
         clr = (r == 0);
         push_en = (r >= 1 && r < 6) || (r == 0);
         wr_en = (r >= 4 && r < 10);
         push_data = pd; wr_addr = wa; wr_data = wd;
         if (clr) begin
            for (int i = 0; i < ND; i++) exp_buf[i] = 8'h20;
         end else if (push_en) begin
            for (int i = ND - 1; i > 0; i--) exp_buf[i] = exp_buf[i-1];
            exp_buf[0] = pd;
         end else if (wr_en) begin
            exp_buf[wa] = wd;
         end
      end
      @(negedge clk);
      clr = 0; push_en = 0; wr_en = 0;
      $display("test_random done: 1000 cycles of mixed updates");
   endtask

   initial begin
      test_reset();
      test_write();
      test_push();
      test_priority();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
